// File: rtl/snake_pkg.sv
// Shared types and constants for the snake item arbiter.
// Holds the FSM encoding, grid constants and an index-width helper.
package snake_pkg;

  localparam int COORD_W_DEF = 4;
  localparam int GRID_COLS   = 1 << COORD_W_DEF;
  localparam int GRID_ROWS   = 1 << COORD_W_DEF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ERASE = 1'b1
  } arb_state_e;

  // clog2 with a floor of 1 so a single slot still has a 1-bit index
  function automatic int idx_w_for(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/snake_item_match_pe.sv
// Head-vs-item comparator with lowest-index priority encoder.
// Purely combinational; instantiated once by the arbiter.
module snake_item_match_pe #(
  parameter int COORD_W   = 4,
  parameter int NUM_ITEMS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [COORD_W-1:0]           head_x,
  input  logic [COORD_W-1:0]           head_y,
  input  logic [NUM_ITEMS*COORD_W-1:0] item_x,
  input  logic [NUM_ITEMS*COORD_W-1:0] item_y,
  input  logic [NUM_ITEMS-1:0]         item_valid,
  output logic                         any_match,
  output logic [IDX_W-1:0]             match_idx
);

  logic [NUM_ITEMS-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      match[i] = item_valid[i]
        && (item_x[i*COORD_W +: COORD_W] == head_x)
        && (item_y[i*COORD_W +: COORD_W] == head_y);
    end
  end

  // Scan high to low so the lowest set slot is the last written
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (match[i]) begin
        any_match = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/snake_item_arbiter.sv
// Multi-slot eat arbiter: picks the eaten item, grows the snake,
// and drives the erase handshake toward the grid renderer.
module snake_item_arbiter
  import snake_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int NUM_ITEMS = 4,
  parameter int IDX_W     = 2,
  parameter int LEN_W     = 8,
  parameter int INIT_LEN  = 3,
  parameter int MAX_LEN   = 255,
  parameter int GROWTH    = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tick,
  input  logic                         restart,
  input  logic [COORD_W-1:0]           head_x,
  input  logic [COORD_W-1:0]           head_y,
  input  logic [NUM_ITEMS*COORD_W-1:0] item_x,
  input  logic [NUM_ITEMS*COORD_W-1:0] item_y,
  input  logic [NUM_ITEMS-1:0]         item_valid,
  output logic                         erase_req,
  output logic [COORD_W-1:0]           erase_x,
  output logic [COORD_W-1:0]           erase_y,
  input  logic                         erase_done,
  output logic                         item_eaten,
  output logic [IDX_W-1:0]             eaten_idx,
  output logic [NUM_ITEMS-1:0]         item_consumed,
  output logic [LEN_W-1:0]             snake_length,
  output logic [LEN_W-1:0]             score,
  output logic                         busy
);

  generate
    if (IDX_W != idx_w_for(NUM_ITEMS)) begin : g_bad_idx_w
      $error("IDX_W does not match NUM_ITEMS");
    end
  endgenerate

  localparam logic [LEN_W:0]   GROW_W  = (LEN_W+1)'(GROWTH);
  localparam logic [LEN_W:0]   MAX_W   = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] INIT_W  = LEN_W'(INIT_LEN);
  localparam logic [NUM_ITEMS-1:0] ONE = NUM_ITEMS'(1);

  arb_state_e           state_q;
  logic                 erase_req_q;
  logic [COORD_W-1:0]   erase_x_q;
  logic [COORD_W-1:0]   erase_y_q;
  logic                 item_eaten_q;
  logic [IDX_W-1:0]     eaten_idx_q;
  logic [NUM_ITEMS-1:0] consumed_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     score_q;

  logic               any_match;
  logic [IDX_W-1:0]   match_idx;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic [LEN_W:0]     len_sum;
  logic [LEN_W:0]     score_sum;
  logic [LEN_W-1:0]   len_d;
  logic [LEN_W-1:0]   score_d;

  snake_item_match_pe #(
    .COORD_W   (COORD_W),
    .NUM_ITEMS (NUM_ITEMS),
    .IDX_W     (IDX_W)
  ) u_pe (
    .head_x     (head_x),
    .head_y     (head_y),
    .item_x     (item_x),
    .item_y     (item_y),
    .item_valid (item_valid),
    .any_match  (any_match),
    .match_idx  (match_idx)
  );

  // Sums carry one extra bit so overflow is visible to the clamp
  always_comb begin
    sel_x     = item_x[match_idx*COORD_W +: COORD_W];
    sel_y     = item_y[match_idx*COORD_W +: COORD_W];
    len_sum   = {1'b0, len_q} + GROW_W;
    score_sum = {1'b0, score_q} + (LEN_W+1)'(1);
    len_d     = (len_sum > MAX_W) ? MAX_W[LEN_W-1:0]
                                  : len_sum[LEN_W-1:0];
    score_d   = score_sum[LEN_W] ? '1 : score_sum[LEN_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      erase_req_q  <= 1'b0;
      erase_x_q    <= '0;
      erase_y_q    <= '0;
      item_eaten_q <= 1'b0;
      eaten_idx_q  <= '0;
      consumed_q   <= '0;
      len_q        <= INIT_W;
      score_q      <= '0;
    end else if (restart) begin
      state_q      <= ST_IDLE;
      erase_req_q  <= 1'b0;
      erase_x_q    <= '0;
      erase_y_q    <= '0;
      item_eaten_q <= 1'b0;
      eaten_idx_q  <= '0;
      consumed_q   <= '0;
      len_q        <= INIT_W;
      score_q      <= '0;
    end else begin
      item_eaten_q <= 1'b0;
      consumed_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (tick && any_match) begin
            state_q      <= ST_ERASE;
            erase_req_q  <= 1'b1;
            erase_x_q    <= sel_x;
            erase_y_q    <= sel_y;
            item_eaten_q <= 1'b1;
            eaten_idx_q  <= match_idx;
            len_q        <= len_d;
            score_q      <= score_d;
          end
        end
        ST_ERASE: begin
          if (erase_done) begin
            state_q     <= ST_IDLE;
            erase_req_q <= 1'b0;
            consumed_q  <= ONE << eaten_idx_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign erase_req     = erase_req_q;
  assign erase_x       = erase_x_q;
  assign erase_y       = erase_y_q;
  assign item_eaten    = item_eaten_q;
  assign eaten_idx     = eaten_idx_q;
  assign item_consumed = consumed_q;
  assign snake_length  = len_q;
  assign score         = score_q;
  assign busy          = (state_q == ST_ERASE);

endmodule

// File: tb/tb_snake_item_arbiter.sv
// Directed bench for snake_item_arbiter with an eat/consume scoreboard.
// Expected eats and consume pulses are queued when stimulus is driven.
module tb_snake_item_arbiter;

  logic        clk;
  logic        resetn;
  logic        tick;
  logic        restart;
  logic [3:0]  head_x;
  logic [3:0]  head_y;
  logic [15:0] item_x;
  logic [15:0] item_y;
  logic [3:0]  item_valid;
  logic        erase_req;
  logic [3:0]  erase_x;
  logic [3:0]  erase_y;
  logic        erase_done;
  logic        item_eaten;
  logic [1:0]  eaten_idx;
  logic [3:0]  item_consumed;
  logic [7:0]  snake_length;
  logic [7:0]  score;
  logic        busy;

  snake_item_arbiter dut (
    .clk           (clk),
    .resetn        (resetn),
    .tick          (tick),
    .restart       (restart),
    .head_x        (head_x),
    .head_y        (head_y),
    .item_x        (item_x),
    .item_y        (item_y),
    .item_valid    (item_valid),
    .erase_req     (erase_req),
    .erase_x       (erase_x),
    .erase_y       (erase_y),
    .erase_done    (erase_done),
    .item_eaten    (item_eaten),
    .eaten_idx     (eaten_idx),
    .item_consumed (item_consumed),
    .snake_length  (snake_length),
    .score         (score),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] len;
    logic [7:0] sc;
  } eat_t;

  eat_t       eat_q[$];
  logic [3:0] cons_q[$];
  int         total = 0;
  int         bad   = 0;
  int         m_len = 3;
  int         m_sc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [3:0] x,
                          input logic [3:0] y, input logic v);
    item_x[s*4 +: 4] = x;
    item_y[s*4 +: 4] = y;
    item_valid[s]    = v;
  endtask

  task automatic push_eat(input logic [1:0] idx, input logic [3:0] x,
                          input logic [3:0] y);
    eat_t e;
    m_len = (m_len + 1 > 255) ? 255 : m_len + 1;
    m_sc  = (m_sc + 1 > 255) ? 255 : m_sc + 1;
    e.idx = idx;
    e.x   = x;
    e.y   = y;
    e.len = 8'(m_len);
    e.sc  = 8'(m_sc);
    eat_q.push_back(e);
    cons_q.push_back(4'b0001 << idx);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Compare the cycle after a tick against the head of the eat queue
  task automatic sample_eat(input string tag);
    eat_t e;
    chk({tag, "_eaten"}, 32'(item_eaten), 32'(eat_q.size() > 0));
    if (eat_q.size() > 0) begin
      e = eat_q.pop_front();
      chk({tag, "_idx"}, 32'(eaten_idx), 32'(e.idx));
      chk({tag, "_ex"}, 32'(erase_x), 32'(e.x));
      chk({tag, "_ey"}, 32'(erase_y), 32'(e.y));
      chk({tag, "_req"}, 32'(erase_req), 32'd1);
      chk({tag, "_len"}, 32'(snake_length), 32'(e.len));
      chk({tag, "_score"}, 32'(score), 32'(e.sc));
    end else begin
      chk({tag, "_len_hold"}, 32'(snake_length), 32'(m_len));
    end
  endtask

  task automatic finish_erase(input string tag, input int wait_n);
    logic [3:0] c;
    erase_done = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      step();
      chk({tag, "_req_hold"}, 32'(erase_req), 32'd1);
      chk({tag, "_cons_early"}, 32'(item_consumed), 32'd0);
    end
    erase_done = 1'b1;
    step();
    erase_done = 1'b0;
    c = (cons_q.size() > 0) ? cons_q.pop_front() : 4'b0000;
    chk({tag, "_req_drop"}, 32'(erase_req), 32'd0);
    chk({tag, "_cons"}, 32'(item_consumed), 32'(c));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_cons_pulse"}, 32'(item_consumed), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(erase_req), 32'd0);
    chk({tag, "_ex"}, 32'(erase_x), 32'd0);
    chk({tag, "_ey"}, 32'(erase_y), 32'd0);
    chk({tag, "_eaten"}, 32'(item_eaten), 32'd0);
    chk({tag, "_idx"}, 32'(eaten_idx), 32'd0);
    chk({tag, "_cons"}, 32'(item_consumed), 32'd0);
    chk({tag, "_len"}, 32'(snake_length), 32'd3);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; restart = 1'b0; erase_done = 1'b0;
    head_x = '0; head_y = '0;
    item_x = '0; item_y = '0; item_valid = '0;
    #12;
    chk_reset_vals("reset");
    step();
    resetn = 1'b1;
    step();

    head_x = 4'd2; head_y = 4'd3;
    set_slot(1, 4'd2, 4'd3, 1'b1);
    push_eat(2'd1, 4'd2, 4'd3);
    do_tick();
    sample_eat("first");
    chk("first_busy", 32'(busy), 32'd1);
    do_tick();
    sample_eat("busy_tick");
    item_valid[1] = 1'b0;
    finish_erase("first", 4);

    item_valid = '0;
    head_x = 4'd5; head_y = 4'd5;
    set_slot(0, 4'd5, 4'd5, 1'b1);
    set_slot(2, 4'd5, 4'd5, 1'b1);
    push_eat(2'd0, 4'd5, 4'd5);
    do_tick();
    sample_eat("prio_lo");
    finish_erase("prio_lo", 0);
    item_valid[0] = 1'b0;
    push_eat(2'd2, 4'd5, 4'd5);
    do_tick();
    sample_eat("prio_hi");
    finish_erase("prio_hi", 1);

    item_valid = '0;
    do_tick();
    sample_eat("invalid");
    head_x = 4'd9;
    item_valid = 4'b1111;
    do_tick();
    sample_eat("nomatch");
    erase_done = 1'b1;
    step();
    erase_done = 1'b0;
    chk("idle_done_cons", 32'(item_consumed), 32'd0);
    chk("idle_done_busy", 32'(busy), 32'd0);

    item_valid = '0;
    head_x = 4'd7; head_y = 4'd7;
    set_slot(3, 4'd7, 4'd7, 1'b1);
    for (int n = 0; n < 253; n++) begin
      push_eat(2'd3, 4'd7, 4'd7);
      do_tick();
      sample_eat("sat");
      finish_erase("sat", 0);
    end
    chk("sat_len", 32'(snake_length), 32'd255);

    push_eat(2'd3, 4'd7, 4'd7);
    do_tick();
    sample_eat("areset_eat");
    #3;
    resetn = 1'b0;
    #1;
    m_len = 3; m_sc = 0;
    void'(cons_q.pop_front());
    chk_reset_vals("areset");
    step();
    resetn = 1'b1;
    step();

    push_eat(2'd3, 4'd7, 4'd7);
    do_tick();
    sample_eat("pre_restart");
    void'(cons_q.pop_front());
    m_len = 3; m_sc = 0;
    restart = 1'b1; tick = 1'b1; erase_done = 1'b1;
    step();
    restart = 1'b0; tick = 1'b0; erase_done = 1'b0;
    chk_reset_vals("restart");

    restart = 1'b1; tick = 1'b1;
    step();
    restart = 1'b0; tick = 1'b0;
    chk_reset_vals("restart_idle");

    chk("eat_q_empty", 32'(eat_q.size()), 32'd0);
    chk("cons_q_empty", 32'(cons_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
